// File: rtl/spi_write_sequencer_if.sv
// Bundle of requester handshakes and SPI pins for spi_write_sequencer.
// The "master" side issues register writes; the "slave" side is the sequencer.
interface spi_write_sequencer_if;
  logic       req0_valid;
  logic [6:0] req0_addr;
  logic [7:0] req0_data;
  logic       req0_ready;

  logic       req1_valid;
  logic [6:0] req1_addr;
  logic [7:0] req1_data;
  logic       req1_ready;

  logic       SCLK;
  logic       nCS;
  logic       COPI;
  logic       busy;
  logic       done;
  logic [7:0] frames_sent;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  SCLK, nCS, COPI, busy, done, frames_sent
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output SCLK, nCS, COPI, busy, done, frames_sent
  );
endinterface

// File: rtl/spi_write_sequencer.sv
// Two-requester SPI write sequencer: round-robin grant, 16-bit MSB-first write frames.
// Optional register shadow that suppresses redundant writes: define SPI_SEQ_SHADOW_EN.
module spi_write_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_write_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [15:0]        shreg_q, shreg_d;
  logic               last_q, last_d;
  logic               ready0_q, ready0_d;
  logic               ready1_q, ready1_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sclk_q, sclk_d;
  logic               ncs_q, ncs_d;
  logic               copi_q, copi_d;
  logic [7:0]         frames_q, frames_d;

  logic               accept;
  logic               grant0, grant1;
  logic               div_end, gap_end;
  logic               active_d;
  logic               skip_hit;

  // The accept cycle is the one in which the registered ready pulse is visible.
  assign accept  = ready0_q | ready1_q;
  assign grant0  = bus.req0_valid & (~bus.req1_valid | last_q);
  assign grant1  = bus.req1_valid & (~bus.req0_valid | ~last_q);
  assign div_end = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign gap_end = (cnt_q == CNT_W'(CS_GAP - 1));

`ifdef SPI_SEQ_SHADOW_EN
  logic [7:0] shadow_data [0:4];
  logic [4:0] shadow_valid;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       frame_done;

  assign frame_done = (state_q == HOLD) && div_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_valid <= '0;
      frame_addr   <= '0;
      frame_data   <= '0;
    end else begin
      if (state_q == IDLE && accept) begin
        frame_addr <= shreg_q[14:8];
        frame_data <= shreg_q[7:0];
      end
      if (frame_done && frame_addr <= 7'd4)
        shadow_valid[frame_addr[2:0]] <= 1'b1;
    end
  end

  // NOTE: shadow storage is deliberately left out of reset; its valid bit gates every read.
  always_ff @(posedge clk) begin
    if (frame_done && frame_addr <= 7'd4)
      shadow_data[frame_addr[2:0]] <= frame_data;
  end

  always_comb begin
    skip_hit = 1'b0;
    if (shreg_q[14:8] <= 7'd4)
      skip_hit = shadow_valid[shreg_q[10:8]] && (shadow_data[shreg_q[10:8]] == shreg_q[7:0]);
  end
`else
  assign skip_hit = 1'b0;
`endif

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    last_d    = last_q;
    ready0_d  = 1'b0;
    ready1_d  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    frames_d  = frames_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (skip_hit) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            state_d   = SETUP;
            bit_cnt_d = '0;
          end
        end else if (grant0 || grant1) begin
          ready0_d = grant0;
          ready1_d = grant1;
          busy_d   = 1'b1;
          last_d   = grant1;
          shreg_d  = grant1 ? {1'b1, bus.req1_addr, bus.req1_data}
                            : {1'b1, bus.req0_addr, bus.req0_data};
        end
      end
      SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (div_end) begin
          cnt_d   = '0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        cnt_d = cnt_q + 1'b1;
        if (div_end) begin
          cnt_d     = '0;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            state_d = HOLD;
          end else begin
            state_d = LOW;
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end
      end
      LOW: begin
        cnt_d = cnt_q + 1'b1;
        if (div_end) begin
          cnt_d   = '0;
          state_d = HIGH;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (div_end) begin
          cnt_d    = '0;
          state_d  = GAP;
          done_d   = 1'b1;
          frames_d = frames_q + 8'd1;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (gap_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pins are decoded from the next state so they change on the same edge as the FSM.
    active_d = (state_d == SETUP) || (state_d == HIGH) || (state_d == LOW) || (state_d == HOLD);
    sclk_d   = (state_d == HIGH);
    ncs_d    = ~active_d;
    copi_d   = active_d & shreg_d[15];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      last_q    <= 1'b1;
      ready0_q  <= 1'b0;
      ready1_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      copi_q    <= 1'b0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      last_q    <= last_d;
      ready0_q  <= ready0_d;
      ready1_q  <= ready1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      ncs_q     <= ncs_d;
      copi_q    <= copi_d;
      frames_q  <= frames_d;
    end
  end

  assign bus.req0_ready  = ready0_q;
  assign bus.req1_ready  = ready1_q;
  assign bus.SCLK        = sclk_q;
  assign bus.nCS         = ncs_q;
  assign bus.COPI        = copi_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_spi_write_sequencer.sv
// Scoreboard bench for spi_write_sequencer: stimulus pushes expected frames, a pin-level
// monitor decodes SCLK/nCS/COPI and compares. Shadow scenarios run when SPI_SEQ_SHADOW_EN is set.
module tb_spi_write_sequencer;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 4;
  localparam int NCS_LOW = CLK_DIV * (2 * 16 + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spi_write_sequencer_if bus ();

  spi_write_sequencer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: expected frame words, pending skips, frame count, arbitration pointer, shadow.
  logic [15:0] exp_q [$];
  int          skip_pending = 0;
  int          model_frames = 0;
  bit          model_last   = 1'b1;
  bit [7:0]    sh_data  [5];
  bit          sh_valid [5];

  function automatic void model_reset();
    exp_q.delete();
    skip_pending = 0;
    model_frames = 0;
    model_last   = 1'b1;
    for (int i = 0; i < 5; i++) sh_valid[i] = 1'b0;
  endfunction

  function automatic void model_issue(input logic [6:0] a, input logic [7:0] d);
`ifdef SPI_SEQ_SHADOW_EN
    int ai = int'(a);
    if (ai <= 4 && sh_valid[ai] && sh_data[ai] == d) begin
      skip_pending++;
      return;
    end
    if (ai <= 4) begin
      sh_valid[ai] = 1'b1;
      sh_data[ai]  = d;
    end
`endif
    exp_q.push_back({1'b1, a, d});
    model_frames++;
  endfunction

  // Monitor: decodes the SPI pins and compares each finished frame against the scoreboard.
  logic [15:0] cap;
  int  bits, low_cnt, gap_cnt, mon_frames;
  bit  had_frame, sclk_p, ncs_p, copi_p;

  always @(negedge clk) begin
    if (!rst_n) begin
      cap = '0; bits = 0; low_cnt = 0; gap_cnt = 0; mon_frames = 0;
      had_frame = 1'b0; sclk_p = 1'b0; ncs_p = 1'b1; copi_p = 1'b0;
    end else begin
      if (!bus.nCS && ncs_p) begin
        if (had_frame) check("cs_gap_min", 32'(gap_cnt >= CS_GAP), 1);
        low_cnt = 0; bits = 0; cap = '0;
      end
      if (!bus.nCS) low_cnt++;
      else gap_cnt++;
      if (bus.SCLK && !sclk_p) begin
        check("sclk_rise_under_cs", 32'(bus.nCS), 0);
        cap = {cap[14:0], bus.COPI};
        bits++;
      end
      if (bus.SCLK && sclk_p) check("copi_stable_high", 32'(bus.COPI), 32'(copi_p));
      if (bus.nCS && !ncs_p) begin
        check("frame_sclk_rises", 32'(bits), 16);
        check("frame_ncs_low_cycles", 32'(low_cnt), NCS_LOW);
        check("frame_done_pulse", 32'(bus.done), 1);
        check("frame_busy", 32'(bus.busy), 1);
        mon_frames++;
        check("frame_count", 32'(bus.frames_sent), 32'(mon_frames % 256));
        if (exp_q.size() > 0) check("frame_word", 32'(cap), 32'(exp_q.pop_front()));
        else check("frame_expected", 32'(exp_q.size()), 1);
        had_frame = 1'b1;
        gap_cnt = 1;
      end else if (bus.done) begin
        check("skip_done_expected", 32'(skip_pending > 0), 1);
        check("skip_busy_low", 32'(bus.busy), 0);
        if (skip_pending > 0) skip_pending--;
      end
      sclk_p = bus.SCLK; ncs_p = bus.nCS; copi_p = bus.COPI;
    end
  end

  task automatic drive(input int idx, input logic [6:0] a, input logic [7:0] d);
    if (idx == 0) begin
      bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_data = d;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_data = d;
    end
  endtask

  // Waits for the ready pulse, then releases valid just after the transfer edge.
  task automatic wait_accept(input int idx);
    bit got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk); #1;
      if ((idx == 0) ? bus.req0_ready : bus.req1_ready) got = 1'b1;
    end
    check((idx == 0) ? "req0_accept" : "req1_accept", 32'(got), 1);
    @(posedge clk); #1;
    if (idx == 0) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
  endtask

  task automatic send(input int idx, input logic [6:0] a, input logic [7:0] d);
    model_issue(a, d);
    drive(idx, a, d);
    wait_accept(idx);
  endtask

  task automatic wait_quiet();
    bit ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && skip_pending == 0 && !bus.busy) ok = 1'b1;
    end
    check("quiet", 32'(ok), 1);
  endtask

  // Both requesters keep a request pending until their lists run out; the model predicts grant order.
  task automatic run_both(input logic [14:0] l0 [$], input logic [14:0] l1 [$]);
    int i0 = 0;
    int i1 = 0;
    while (i0 < l0.size() || i1 < l1.size()) begin
      bit w;
      if (i0 < l0.size() && i1 < l1.size()) w = ~model_last;
      else w = (i0 < l0.size()) ? 1'b0 : 1'b1;
      model_last = w;
      if (!w) begin model_issue(l0[i0][14:8], l0[i0][7:0]); i0++; end
      else    begin model_issue(l1[i1][14:8], l1[i1][7:0]); i1++; end
    end
    fork
      begin
        for (int k = 0; k < l0.size(); k++) begin drive(0, l0[k][14:8], l0[k][7:0]); wait_accept(0); end
      end
      begin
        for (int k = 0; k < l1.size(); k++) begin drive(1, l1[k][14:8], l1[k][7:0]); wait_accept(1); end
      end
    join
  endtask

  task automatic send_one(input logic [6:0] a, input logic [7:0] d);
    int idx = int'($urandom_range(0, 1));
    model_last = idx[0];
    send(idx, a, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [14:0] l0 [$];
    logic [14:0] l1 [$];
    int  rises;
    bit  got, sp;

    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    model_reset();

    #12;
    check("rst_sclk", 32'(bus.SCLK), 0);
    check("rst_ncs", 32'(bus.nCS), 1);
    check("rst_copi", 32'(bus.COPI), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 0);
    check("rst_frames", 32'(bus.frames_sent), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single write 0x04/0xA5.
    model_last = 1'b0;
    send(0, 7'h04, 8'hA5);
    wait_quiet();
    check("frames_after_first", 32'(bus.frames_sent), 1);

`ifdef SPI_SEQ_SHADOW_EN
    send(1, 7'h01, 8'h3C);
    wait_quiet();
    send(1, 7'h01, 8'h3C);
    check("skip_done_now", 32'(bus.done), 1);
    check("skip_ncs_idle", 32'(bus.nCS), 1);
    wait_quiet();
    send(1, 7'h01, 8'h3D);
    wait_quiet();
    check("frames_after_shadow", 32'(bus.frames_sent), 32'(model_frames % 256));
`endif

    // Simultaneous requests, then both requesters kept busy for four frames.
    l0 = '{ {7'h02, 8'h11} };
    l1 = '{ {7'h03, 8'h22} };
    run_both(l0, l1);
    wait_quiet();
    check("frames_after_pair", 32'(bus.frames_sent), 32'(model_frames % 256));

    l0 = '{ {7'h20, 8'hA0}, {7'h21, 8'hA1} };
    l1 = '{ {7'h30, 8'hB0}, {7'h31, 8'hB1} };
    run_both(l0, l1);
    wait_quiet();

    for (int n = 0; n < 6; n++) send_one(7'($urandom_range(0, 127)), 8'($urandom));
    wait_quiet();
    check("frames_after_random", 32'(bus.frames_sent), 32'(model_frames % 256));

    // Abort during the 8th SCLK high phase.
    send(0, 7'h10, 8'h5A);
    rises = 0; got = 1'b0; sp = bus.SCLK;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.SCLK && !sp) rises++;
      sp = bus.SCLK;
      if (rises == 8) got = 1'b1;
    end
    check("eighth_rise_seen", 32'(got), 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_ncs", 32'(bus.nCS), 1);
    check("abort_sclk", 32'(bus.SCLK), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_frames", 32'(bus.frames_sent), 0);
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send(1, 7'h05, 8'hC3);
    wait_quiet();
    check("frames_after_abort", 32'(bus.frames_sent), 1);

    // Drive the counter through 255 and wrap to 0.
    while (model_frames < 255) send_one(7'($urandom_range(5, 127)), 8'($urandom));
    wait_quiet();
    check("frames_at_255", 32'(bus.frames_sent), 255);
    send_one(7'($urandom_range(5, 127)), 8'($urandom));
    wait_quiet();
    check("frames_wrap", 32'(bus.frames_sent), 0);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/spi_write_sequencer.md
Name: spi_write_sequencer

Overview:
- SPI controller that drives the team's SPI register peripheral: SCLK, nCS and COPI.
- Arbitrates between two on-chip requesters, each offering a 7-bit register address and 8 bits of data.
- Serialises each granted request as one 16-bit write frame, MSB first: bit15 = 1 (write), bits14:8 = address, bits7:0 = data.
- Sits in the same clock domain as the peripheral. The peripheral's 2-flop synchroniser sets the minimum SCLK phase length.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK phase (half-period). Must be >= 4.
- CS_GAP, 4: minimum clk cycles nCS stays high between frames. Must be >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has a write pending
- req0_addr  input  7  requester 0 register address
- req0_data  input  8  requester 0 register data
- req0_ready  output  1  requester 0 accept strobe
- req1_valid  input  1  requester 1 has a write pending
- req1_addr  input  7  requester 1 register address
- req1_data  input  8  requester 1 register data
- req1_ready  output  1  requester 1 accept strobe
- SCLK  output  1  SPI clock, idles low
- nCS  output  1  SPI chip select, active low, idles high
- COPI  output  1  SPI data to peripheral
- busy  output  1  high from the accept cycle until the end of GAP
- done  output  1  one-cycle pulse on the cycle nCS returns high
- frames_sent  output  8  count of completed frames, wraps 255 -> 0

Behaviour:
- Reset (async, rst_n low) forces immediately:
  - SCLK = 0, nCS = 1, COPI = 0; busy, done, req*_ready = 0; frames_sent = 0.
  - FSM = IDLE; round-robin pointer last = 1, so requester 0 wins the first tie.
- Reset mid-frame aborts the frame; nothing is retried. nCS rises with no 16th SCLK rise, so the peripheral does not commit.
- All outputs are registered.
- Arbitration, in IDLE only:
  - If exactly one valid is high, grant it.
  - If both are high, grant the one not equal to last, then set last = granted index.
  - reqN_ready is a registered pulse in the accept cycle: valid & ready = transfer.
  - Address and data are latched into a 16-bit shift register as {1'b1, addr, data}.
  - Requesters must hold addr/data stable while valid is high and ready is low.
  - Ready never asserts outside IDLE.
- FSM states:
  - IDLE: wait for a grant, then -> SETUP.
  - SETUP: nCS = 0, SCLK = 0, COPI = bit15, for CLK_DIV cycles. -> HIGH.
  - HIGH: SCLK = 1 for CLK_DIV cycles; bit counter +1 at the end of the phase. If the counter reaches 16 -> HOLD, else -> LOW.
  - LOW: SCLK = 0, shift register shifts left and COPI = next bit at phase entry, for CLK_DIV cycles. -> HIGH.
  - HOLD: SCLK = 0, nCS = 0 for CLK_DIV cycles. Then nCS = 1, done pulses, frames_sent += 1 -> GAP.
  - GAP: nCS = 1 for CS_GAP cycles. -> IDLE.
- Bit counter is 5 bits.
- COPI changes only while SCLK is low, so it is stable for the full high phase and the peripheral samples on the rising edge.
- Frame length: 1 + CLK_DIV*(1 + 2*16 - 1 + 1) + CS_GAP cycles from accept to IDLE. With defaults: 1 + 4*33 + 4 = 137.
- Exactly 16 SCLK rising edges per frame.
- Addresses above 0x04 are sent unchanged; the peripheral ignores them.

Optional Feature:
- Macro: SPI_SEQ_SHADOW_EN
- Defined:
  - Keeps shadow copies of registers 0x00–0x04, each with a valid bit; all valid bits clear on reset.
  - Normal path: after a completed frame, the shadow for that address is updated and marked valid.
  - Skip path: an accepted request whose addr <= 0x04 and whose data equals a valid shadow is still acknowledged (ready pulses), but no frame is sent. SCLK, nCS and COPI stay idle and frames_sent is unchanged. done pulses in the cycle after accept, busy is high for that one cycle, then IDLE.
  - An aborted frame does not update the shadow.
- Not defined: every accepted request produces a frame; no shadow state exists.

Test Plan:
- req0 addr 0x04, data 0xA5, defaults -> nCS low for 132 cycles; 16 SCLK rises sample COPI = 1,0000100,10100101; done pulses once; frames_sent = 1.
- req0 and req1 valid in the same cycle (0x02/0x11, 0x03/0x22) -> req0 frame first, then req1; back-to-back frames are separated by >= CS_GAP nCS-high cycles; frames_sent = 2.
- Both requesters hold valid for 4 frames -> grant order 0,1,0,1.
- rst_n low during the 8th SCLK high phase -> same cycle: nCS = 1, SCLK = 0, busy = 0. After release, a new request completes normally.
- frames_sent preloaded to 255 by 255 frames, then one more frame -> frames_sent = 0.
- With SPI_SEQ_SHADOW_EN: write 0x01/0x3C twice -> one frame only; second request acknowledged with done, no SCLK edges. Then 0x01/0x3D -> frame sent.
